// File: rtl/if_stage_pkg.sv
// Shared pipeline constants for the fetch stage: reset vector, fetch-to-decode
// bus width and field offsets, and the next-PC source encoding.
package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD_DEF = 65;
  localparam logic [31:0] RESET_PC_DEF        = 32'h1c00_0000;

  // fs_to_ds_bus layout: {csr_vec_h, excp_adef, fs_pc}
  localparam int FS_PC_LSB   = 0;
  localparam int FS_ADEF_BIT = 32;
  localparam int FS_CSR_LSB  = 33;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_FLUSH,
    NPC_HOLD,
    NPC_BR,
    NPC_BUF
  } npc_sel_e;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// One-entry buffer that remembers a taken branch seen while IF is stalled,
// so the redirect is applied on the first unstalled edge instead of lost.
module if_redirect_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        set,
  input  logic        clr,
  input  logic [31:0] tgt_in,
  output logic        valid,
  output logic [31:0] tgt_out
);

  logic        valid_q;
  logic [31:0] tgt_q;

  // flush outranks a same-cycle set: the exception redirect wins
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
    end else if (set) begin
      valid_q <= 1'b1;
    end else if (clr) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= '0;
    end else if (set) begin
      tgt_q <= tgt_in;
    end
  end

  assign valid   = valid_q;
  assign tgt_out = tgt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: holds fs_pc, selects the next PC, drives the
// instruction SRAM and packs the fetch-to-decode bus. Option: IF_REDIRECT_BUF_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          FS_TO_DS_BUS_WD = FS_TO_DS_BUS_WD_DEF,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic [5:0]                 stall,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  output logic                       pc_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  logic [31:0] fs_pc_q, fs_pc_d;
  logic        pc_valid_q;
  logic [31:0] fs_pc;
  logic        excp_adef;
  logic [31:0] csr_vec_h;
  logic        buf_valid;
  logic [31:0] buf_tgt;
  npc_sel_e    npc_sel;
  logic        unused_stall;

  // only bit 0 belongs to this stage
  assign unused_stall = ^stall[5:1];

`ifdef IF_REDIRECT_BUF_EN
  if_redirect_buf u_redirect_buf (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .set     (br_taken & stall[0]),
    .clr     (~stall[0]),
    .tgt_in  (br_target),
    .valid   (buf_valid),
    .tgt_out (buf_tgt)
  );
`else
  assign buf_valid = 1'b0;
  assign buf_tgt   = '0;

  // pipeline control must never resolve a branch into a stalled IF
  a_no_br_in_stall: assert property (@(posedge clk) disable iff (reset)
    !(br_taken && stall[0]));
`endif

  always_comb begin
    npc_sel = NPC_SEQ;
    if (flush)          npc_sel = NPC_FLUSH;
    else if (stall[0])  npc_sel = NPC_HOLD;
    else if (br_taken)  npc_sel = NPC_BR;
    else if (buf_valid) npc_sel = NPC_BUF;
  end

  always_comb begin
    fs_pc_d = fs_pc_q + 32'd4;
    case (npc_sel)
      NPC_FLUSH: fs_pc_d = new_pc;
      NPC_HOLD:  fs_pc_d = fs_pc_q;
      NPC_BR:    fs_pc_d = br_target;
      NPC_BUF:   fs_pc_d = buf_tgt;
      default:   fs_pc_d = fs_pc_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_pc_q    <= RESET_PC;
      pc_valid_q <= 1'b0;
    end else begin
      fs_pc_q    <= fs_pc_d;
      pc_valid_q <= 1'b1;
    end
  end

  // reset gating keeps outputs defined even before the first reset edge
  assign fs_pc     = reset ? RESET_PC : fs_pc_q;
  assign pc_valid  = pc_valid_q & ~reset;
  assign excp_adef = pc_misaligned(fs_pc);
  assign csr_vec_h = excp_adef ? fs_pc : 32'b0;

  assign inst_sram_en    = pc_valid & ~excp_adef;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = fs_pc;
  assign inst_sram_wdata = 32'b0;

  always_comb begin
    fs_to_ds_bus                          = '0;
    fs_to_ds_bus[FS_PC_LSB +: 32]         = fs_pc;
    fs_to_ds_bus[FS_ADEF_BIT]             = excp_adef;
    fs_to_ds_bus[FS_CSR_LSB +: 32]        = csr_vec_h;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage, plus hand-written multi-cycle
// sequences (redirect buffer ones only when IF_REDIRECT_BUF_EN is defined).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] new_pc;
  logic [5:0]  stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        pc_valid;
  logic [64:0] fs_to_ds_bus;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .new_pc          (new_pc),
    .stall           (stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .pc_valid        (pc_valid),
    .fs_to_ds_bus    (fs_to_ds_bus)
  );

  // inputs applied this cycle; expected outputs seen this cycle (state from
  // the previous edge, reset gating applied combinationally)
  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] npc;
    logic [5:0]  st;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_en;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic [31:0] npc,
                       input logic [5:0] st, input logic br, input logic [31:0] tgt);
    reset = rst; flush = fl; new_pc = npc; stall = st; br_taken = br; br_target = tgt;
  endtask

  task automatic check_pc(input string name, input logic [31:0] pc, input logic v, input logic en);
    logic        adef;
    logic [64:0] bus;
    adef = (pc[1:0] != 2'b00);
    bus  = {(adef ? pc : 32'h0), adef, pc};
    chk({name, ".addr"},  {33'b0, inst_sram_addr}, {33'b0, pc});
    chk({name, ".valid"}, {64'b0, pc_valid},       {64'b0, v});
    chk({name, ".en"},    {64'b0, inst_sram_en},   {64'b0, en});
    chk({name, ".bus"},   fs_to_ds_bus,            bus);
  endtask

  // one cycle: drive at negedge, compare #1 later, state advances at posedge
  task automatic step(input string name, input logic rst, input logic fl, input logic [31:0] npc,
                      input logic [5:0] st, input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic e_v, input logic e_en);
    @(negedge clk);
    drive(rst, fl, npc, st, br, tgt);
    #1;
    check_pc(name, e_pc, e_v, e_en);
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0);

    //           rst   fl    new_pc        stall  br    br_target     exp pc        v     en
    tv.push_back('{1'b1, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0});
    tv.push_back('{1'b1, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000004, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h3e, 1'b0, 32'h0,        32'h1c000008, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b1, 32'h1c000100, 32'h1c00000c, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000100, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000104, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b1, 32'h1c008000, 6'h00, 1'b1, 32'h1c000100, 32'h1c000108, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c008000, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b1, 32'h1c000010, 6'h00, 1'b0, 32'h0,        32'h1c008004, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h01, 1'b0, 32'h0,        32'h1c000010, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h01, 1'b0, 32'h0,        32'h1c000010, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h01, 1'b0, 32'h0,        32'h1c000010, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000010, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b1, 32'h1c000002, 6'h01, 1'b0, 32'h0,        32'h1c000014, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000002, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b1, 32'h1c000020, 6'h00, 1'b0, 32'h0,        32'h1c000006, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h01, 1'b0, 32'h0,        32'h1c000020, 1'b1, 1'b1});
    tv.push_back('{1'b1, 1'b0, 32'h0,        6'h01, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 32'hfffffffc, 6'h00, 1'b0, 32'h0,        32'h1c000004, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'hfffffffc, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h00000000, 1'b1, 1'b1});

    for (int i = 0; i < tv.size(); i++) begin
      step($sformatf("vec%0d", i), tv[i].rst, tv[i].fl, tv[i].npc, tv[i].st,
           tv[i].br, tv[i].tgt, tv[i].e_pc, tv[i].e_v, tv[i].e_en);
      chk($sformatf("vec%0d.we", i),    {61'b0, inst_sram_we}, 65'b0);
      chk($sformatf("vec%0d.wdata", i), {33'b0, inst_sram_wdata}, 65'b0);
    end

    // branch on the very cycle a 2-cycle stall releases
    step("seqA0", 1'b1, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0, 32'h1c000000, 1'b0, 1'b0);
    step("seqA1", 1'b0, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0, 32'h1c000000, 1'b0, 1'b0);
    step("seqA2", 1'b0, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0, 32'h1c000000, 1'b1, 1'b1);
    step("seqA3", 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 32'h1c000400, 32'h1c000000, 1'b1, 1'b1);
    step("seqA4", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0, 32'h1c000400, 1'b1, 1'b1);
    step("seqA5", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0, 32'h1c000404, 1'b1, 1'b1);

`ifdef IF_REDIRECT_BUF_EN
    // buffered branch during a 2-cycle stall
    step("bufA0", 1'b0, 1'b0, 32'h0, 6'h01, 1'b1, 32'h1c000200, 32'h1c000408, 1'b1, 1'b1);
    step("bufA1", 1'b0, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0,        32'h1c000408, 1'b1, 1'b1);
    step("bufA2", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000408, 1'b1, 1'b1);
    step("bufA3", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000200, 1'b1, 1'b1);
    step("bufA4", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000204, 1'b1, 1'b1);
    // overwrite while still stalled
    step("bufB0", 1'b0, 1'b0, 32'h0, 6'h01, 1'b1, 32'h1c000300, 32'h1c000208, 1'b1, 1'b1);
    step("bufB1", 1'b0, 1'b0, 32'h0, 6'h01, 1'b1, 32'h1c000400, 32'h1c000208, 1'b1, 1'b1);
    step("bufB2", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000208, 1'b1, 1'b1);
    step("bufB3", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000400, 1'b1, 1'b1);
    // new unstalled branch beats the pending entry
    step("bufC0", 1'b0, 1'b0, 32'h0, 6'h01, 1'b1, 32'h1c000500, 32'h1c000404, 1'b1, 1'b1);
    step("bufC1", 1'b0, 1'b0, 32'h0, 6'h00, 1'b1, 32'h1c000600, 32'h1c000404, 1'b1, 1'b1);
    step("bufC2", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000600, 1'b1, 1'b1);
    step("bufC3", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000604, 1'b1, 1'b1);
    // flush clears the entry
    step("bufD0", 1'b0, 1'b0, 32'h0,        6'h01, 1'b1, 32'h1c000700, 32'h1c000608, 1'b1, 1'b1);
    step("bufD1", 1'b0, 1'b1, 32'h1c009000, 6'h01, 1'b0, 32'h0,        32'h1c000608, 1'b1, 1'b1);
    step("bufD2", 1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c009000, 1'b1, 1'b1);
    step("bufD3", 1'b0, 1'b0, 32'h0,        6'h00, 1'b0, 32'h0,        32'h1c009004, 1'b1, 1'b1);
    // reset while an entry is pending discards it
    step("bufE0", 1'b0, 1'b0, 32'h0, 6'h01, 1'b1, 32'h1c000800, 32'h1c009008, 1'b1, 1'b1);
    step("bufE1", 1'b1, 1'b0, 32'h0, 6'h01, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0);
    step("bufE2", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000000, 1'b0, 1'b0);
    step("bufE3", 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 32'h0,        32'h1c000004, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
